stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl_if.sv | 24 ++
 rtl/stopwatch_ctrl.sv | 151 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch controller and its counter/display/button side.
interface stopwatch_ctrl_if;
    logic       tick_1hz;
    logic       btn_ss;
    logic       btn_lr;
    logic [7:0] cur_min;
    logic [5:0] cur_sec;
    logic       count_enable;
    logic       clear;
    logic [7:0] disp_min;
    logic [5:0] disp_sec;
    logic [1:0] status;
    logic [3:0] lap_count;

    modport master (
        output tick_1hz, btn_ss, btn_lr, cur_min, cur_sec,
        input  count_enable, clear, disp_min, disp_sec, status, lap_count
    );

    modport slave (
        input  tick_1hz, btn_ss, btn_lr, cur_min, cur_sec,
        output count_enable, clear, disp_min, disp_sec, status, lap_count
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button sync/debounce, IDLE/RUN/PAUSE/LAP state machine,
// lap latch with auto-return hold timer, lap counter and display mux.
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LAP_HOLD_SEC    = 5
) (
    input  logic            clk,
    input  logic            rst,
    stopwatch_ctrl_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LAP_HOLD_SEC + 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LAP_HOLD_SEC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    // bit 0 = start/stop, bit 1 = lap/reset
    logic [1:0]         raw, sync1, sync2, deb, deb_q, press;
    logic [1:0][CW-1:0] db_cnt;
    logic               ss, lr;

    assign raw = {bus.btn_lr, bus.btn_ss};
    assign ss  = press[0];
    assign lr  = press[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            deb    <= '0;
            deb_q  <= '0;
            press  <= '0;
            db_cnt <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            press <= deb & ~deb_q;
            for (int b = 0; b < 2; b++) begin
                // any cycle where the synchronized level agrees restarts the count
                if (sync2[b] == deb[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == DB_LAST) begin
                    deb[b]    <= sync2[b];
                    db_cnt[b] <= '0;
                end else begin
                    db_cnt[b] <= db_cnt[b] + 1'b1;
                end
            end
        end
    end

    state_t        state, state_n;
    logic          capture, clear_n, hold_inc;
    logic [HW-1:0] hold_cnt;
    logic [7:0]    lap_min, disp_min;
    logic [5:0]    lap_sec, disp_sec;
    logic [3:0]    lap_count;
    logic          count_enable, clear;

    // ss has priority over lr; any press pre-empts a same-cycle hold expiry
    always_comb begin
        state_n  = state;
        capture  = 1'b0;
        clear_n  = 1'b0;
        hold_inc = 1'b0;
        unique case (state)
            IDLE: begin
                if (ss)      state_n = RUN;
                else if (lr) clear_n = 1'b1;
            end
            RUN: begin
                if (ss) begin
                    state_n = PAUSE;
                end else if (lr) begin
                    state_n = LAP;
                    capture = 1'b1;
                end
            end
            LAP: begin
                if (ss) begin
                    state_n = PAUSE;
                end else if (lr) begin
                    capture = 1'b1;
                end else if (bus.tick_1hz) begin
                    if (hold_cnt == HOLD_LAST) state_n  = RUN;
                    else                       hold_inc = 1'b1;
                end
            end
            PAUSE: begin
                if (ss) begin
                    state_n = RUN;
                end else if (lr) begin
                    state_n = IDLE;
                    clear_n = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            lap_min      <= '0;
            lap_sec      <= '0;
            lap_count    <= '0;
            disp_min     <= '0;
            disp_sec     <= '0;
            count_enable <= 1'b0;
            clear        <= 1'b0;
        end else begin
            state        <= state_n;
            clear        <= clear_n;
            count_enable <= (state == RUN) || (state == LAP);

            if (capture)       hold_cnt <= '0;
            else if (hold_inc) hold_cnt <= hold_cnt + 1'b1;

            if (capture) begin
                lap_min <= bus.cur_min;
                lap_sec <= bus.cur_sec;
            end

            if (clear_n)                           lap_count <= '0;
            else if (capture && lap_count != 4'hF) lap_count <= lap_count + 1'b1;

            // in LAP the display shows the latch (fresh value on the capture edge)
            if (state_n == LAP && !capture) begin
                disp_min <= lap_min;
                disp_sec <= lap_sec;
            end else begin
                disp_min <= bus.cur_min;
                disp_sec <= bus.cur_sec;
            end
        end
    end

    assign bus.status       = state;
    assign bus.count_enable = count_enable;
    assign bus.clear        = clear;
    assign bus.disp_min     = disp_min;
    assign bus.disp_sec     = disp_sec;
    assign bus.lap_count    = lap_count;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random stimulus, with every
// cycle's outputs checked against a queue filled by a behavioural reference model.
module tb_stopwatch_ctrl;
    localparam int D = 4;
    localparam int H = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stopwatch_ctrl_if bus();

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(D), .LAP_HOLD_SEC(H)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [1:0] st;
        logic       ce;
        logic       clr;
        logic [7:0] dm;
        logic [5:0] ds;
        logic [3:0] lc;
    } obs_t;

    int   errors = 0;
    int   checks = 0;
    int   sb_count = 0;
    int   clr_seen = 0;
    obs_t expq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: modes 0 idle, 1 run, 2 pause, 3 lap
    int         m_mode, m_laps, m_hold;
    logic [7:0] m_lmin;
    logic [5:0] m_lsec;
    bit         m_deb[2];
    bit         rd1[2], rd2[2];
    bit         rawh[2][D+2];

    task automatic m_reset();
        m_mode = 0; m_laps = 0; m_hold = 0; m_lmin = '0; m_lsec = '0;
        for (int b = 0; b < 2; b++) begin
            m_deb[b] = 1'b0; rd1[b] = 1'b0; rd2[b] = 1'b0;
            for (int i = 0; i < D + 2; i++) rawh[b][i] = 1'b0;
        end
    endtask

    task automatic m_step(input bit tk, input bit [1:0] raw, input logic [7:0] cm, input logic [5:0] cs);
        obs_t e;
        bit   ss, lr, all, rise;
        ss = rd2[0];
        lr = rd2[1];
        e = '0;
        e.ce = (m_mode == 1 || m_mode == 3);
        if (ss) begin
            m_mode = (m_mode == 1 || m_mode == 3) ? 2 : 1;
        end else if (lr) begin
            if (m_mode == 0 || m_mode == 2) begin
                e.clr = 1'b1; m_laps = 0; m_mode = 0;
            end else begin
                m_mode = 3; m_lmin = cm; m_lsec = cs; m_hold = 0;
                if (m_laps < 15) m_laps++;
            end
        end else if (m_mode == 3 && tk) begin
            m_hold++;
            if (m_hold == H) m_mode = 1;
        end
        e.st = 2'(m_mode);
        e.lc = 4'(m_laps);
        e.dm = (m_mode == 3) ? m_lmin : cm;
        e.ds = (m_mode == 3) ? m_lsec : cs;
        // debounced level flips once the raw samples taken 2..D+1 edges ago all disagree with it
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < D + 1; i++) rawh[b][i] = rawh[b][i+1];
            rawh[b][D+1] = raw[b];
            all = 1'b1;
            for (int i = 0; i < D; i++) if (rawh[b][i] == m_deb[b]) all = 1'b0;
            rise = 1'b0;
            if (all) begin
                rise = !m_deb[b];
                m_deb[b] = !m_deb[b];
            end
            rd2[b] = rd1[b];
            rd1[b] = rise;
        end
        expq.push_back(e);
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_reset();
                expq.delete();
                expq.push_back('0);
            end else begin
                m_step(bus.tick_1hz, {bus.btn_lr, bus.btn_ss}, bus.cur_min, bus.cur_sec);
            end
        end
    end

    initial begin
        obs_t e, act;
        forever begin
            @(negedge clk);
            if (bus.clear === 1'b1) clr_seen++;
            if (expq.size() > 1) begin
                errors++;
                $display("FAIL sb_depth: got %0d pending, expected at most 1", expq.size());
            end
            if (expq.size() != 0) begin
                e = expq.pop_front();
                act = {bus.status, bus.count_enable, bus.clear, bus.disp_min, bus.disp_sec, bus.lap_count};
                sb_count++;
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL sb @%0t: got st=%0d ce=%0d clr=%0d disp=%0d:%0d laps=%0d, expected st=%0d ce=%0d clr=%0d disp=%0d:%0d laps=%0d",
                             $time, act.st, act.ce, act.clr, act.dm, act.ds, act.lc,
                             e.st, e.ce, e.clr, e.dm, e.ds, e.lc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input bit ss, input bit lr);
        if (ss) bus.btn_ss = 1'b1;
        if (lr) bus.btn_lr = 1'b1;
        cyc(D + 4);
        bus.btn_ss = 1'b0;
        bus.btn_lr = 1'b0;
        cyc(D + 4);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            bus.tick_1hz = 1'b1;
            cyc(1);
            bus.tick_1hz = 1'b0;
            cyc(2);
        end
    endtask

    function automatic logic [21:0] outs();
        return {bus.status, bus.count_enable, bus.clear, bus.disp_min, bus.disp_sec, bus.lap_count};
    endfunction

    initial begin
        int c0, hs, hl;
        bus.tick_1hz = 1'b0; bus.btn_ss = 1'b0; bus.btn_lr = 1'b0;
        bus.cur_min = 8'd0; bus.cur_sec = 6'd0;
        #2 rst = 1'b1;
        cyc(3);
        chk("reset_outs", outs(), 22'd0);
        rst = 1'b0;
        cyc(2);

        // short glitch is rejected, long hold starts the watch at the exact cycle
        bus.btn_ss = 1'b1; cyc(3); bus.btn_ss = 1'b0; cyc(12);
        chk("short_press_status", bus.status, 2'b00);
        bus.btn_ss = 1'b1;
        cyc(7);  chk("pre_run_status", bus.status, 2'b00);
        cyc(1);  chk("run_cycle7", bus.status, 2'b01);
        chk("ce_cycle7", bus.count_enable, 1'b0);
        cyc(1);  chk("ce_cycle8", bus.count_enable, 1'b1);
        cyc(1);  bus.btn_ss = 1'b0; cyc(D + 6);

        // lap capture, frozen display, auto-return after H ticks
        bus.cur_min = 8'd3; bus.cur_sec = 6'd25;
        press(1'b0, 1'b1);
        chk("lap_status", bus.status, 2'b11);
        chk("lap_disp", {bus.disp_min, bus.disp_sec}, {8'd3, 6'd25});
        chk("lap_count1", bus.lap_count, 4'd1);
        bus.cur_sec = 6'd27; cyc(3);
        chk("disp_frozen", bus.disp_sec, 6'd25);
        ticks(H);
        chk("hold_expire", bus.status, 2'b01);
        bus.cur_sec = 6'd30; cyc(2);
        chk("disp_track", bus.disp_sec, 6'd30);

        // recapture restarts the hold timer
        press(1'b0, 1'b1);
        ticks(4);
        press(1'b0, 1'b1);
        chk("recapture_laps", bus.lap_count, 4'd3);
        ticks(H - 1);
        chk("no_early_return", bus.status, 2'b11);
        ticks(1);
        chk("hold_expire2", bus.status, 2'b01);

        // simultaneous presses: ss wins, lap count untouched
        press(1'b1, 1'b1);
        chk("both_status", bus.status, 2'b10);
        chk("both_laps", bus.lap_count, 4'd3);

        // clearing presses from PAUSE and IDLE
        c0 = clr_seen;
        press(1'b0, 1'b1);
        chk("pause_clear_once", clr_seen - c0, 1);
        chk("pause_clear_status", bus.status, 2'b00);
        chk("pause_clear_laps", bus.lap_count, 4'd0);
        c0 = clr_seen;
        press(1'b0, 1'b1);
        chk("idle_clear_once", clr_seen - c0, 1);

        // lap counter saturation
        press(1'b1, 1'b0);
        repeat (17) press(1'b0, 1'b1);
        chk("lap_saturate", bus.lap_count, 4'd15);
        chk("lap_sat_status", bus.status, 2'b11);

        // asynchronous reset mid-LAP, button held through deassertion
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("async_reset", outs(), 22'd0);
        bus.btn_ss = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(D + 3); chk("held_pre_press", bus.status, 2'b00);
        cyc(1);     chk("held_thru_reset", bus.status, 2'b01);
        bus.btn_ss = 1'b0;
        cyc(D + 6);

        // random phase
        hs = 0; hl = 0;
        for (int c = 0; c < 4000; c++) begin
            bus.tick_1hz = ($urandom_range(0, 3) == 0);
            bus.cur_min  = 8'($urandom_range(0, 255));
            bus.cur_sec  = 6'($urandom_range(0, 59));
            if (hs == 0 && $urandom_range(0, 25) == 0) hs = $urandom_range(1, 2 * D + 4);
            if (hl == 0 && $urandom_range(0, 25) == 0) hl = (hs != 0 && $urandom_range(0, 1) == 1) ? hs : $urandom_range(1, 2 * D + 4);
            bus.btn_ss = (hs != 0);
            bus.btn_lr = (hl != 0);
            if (hs != 0) hs--;
            if (hl != 0) hl--;
            cyc(1);
        end
        bus.tick_1hz = 1'b0; bus.btn_ss = 1'b0; bus.btn_lr = 1'b0;
        cyc(D + 6);
        chk("sb_activity", (sb_count > 4000), 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
